// File: rtl/menu_accion_decoder.sv
// Menu action decoder: turns a select pulse at a (fila, columna) cursor into registered text
// settings and new/save/close commands. Optional macro: CONFIRMA_CERRAR_EN (two-press close).
module menu_accion_decoder #(
    parameter logic [26:0] TIMEOUT_CICLOS = 27'd100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       elige,
    input  logic [2:0] where_fila,
    input  logic [2:0] where_columna,
    input  logic       guardar_ack,
    output logic       text_red,
    output logic       text_green,
    output logic       text_blue,
    output logic [9:0] char_scale,
    output logic       es_mayuscula,
    output logic       nuevo,
    output logic       guardar,
    output logic       cerrar,
    output logic       confirma_pendiente,
    output logic       ocupado
);

    localparam logic [1:0] REPOSO    = 2'd0;
    localparam logic [1:0] GUARDANDO = 2'd1;
`ifdef CONFIRMA_CERRAR_EN
    localparam logic [1:0] CONFIRMA  = 2'd2;
`endif

    logic [1:0] r_estado;
    logic [2:0] r_rgb;
    logic [9:0] r_scale;
    logic       r_mayus;
    logic       r_nuevo;
    logic       r_guardar;
    logic       r_cerrar;
    logic       r_ocupado;
`ifdef CONFIRMA_CERRAR_EN
    logic [26:0] r_contador;
    logic        r_confirma;
`endif

    logic       w_rgb_ok;
    logic [2:0] w_rgb;
    logic       w_scale_ok;
    logic [9:0] w_scale;
    logic       w_mayus_ok;

    // Column lookups per settings row; the *_ok flags reject columns outside each row's range.
    always_comb begin
        w_rgb_ok   = 1'b1;
        w_rgb      = 3'b000;
        w_scale_ok = 1'b1;
        w_scale    = 10'd0;
        case (where_columna)
            3'd1: w_rgb = 3'b001;
            3'd2: w_rgb = 3'b010;
            3'd3: w_rgb = 3'b100;
            3'd4: w_rgb = 3'b011;
            3'd5: w_rgb = 3'b101;
            3'd6: w_rgb = 3'b110;
            default: w_rgb_ok = 1'b0;
        endcase
        case (where_columna)
            3'd1: w_scale = 10'd1;
            3'd2: w_scale = 10'd2;
            3'd3: w_scale = 10'd4;
            default: w_scale_ok = 1'b0;
        endcase
        w_mayus_ok = (where_columna == 3'd1) || (where_columna == 3'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado  <= REPOSO;
            r_rgb     <= 3'b001;
            r_scale   <= 10'd2;
            r_mayus   <= 1'b1;
            r_nuevo   <= 1'b0;
            r_guardar <= 1'b0;
            r_cerrar  <= 1'b0;
            r_ocupado <= 1'b0;
`ifdef CONFIRMA_CERRAR_EN
            r_contador <= 27'd0;
            r_confirma <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle so a later branch can only raise them for one cycle.
            r_nuevo  <= 1'b0;
            r_cerrar <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (elige) begin
                        case (where_fila)
                            3'd1: r_nuevo <= 1'b1;
                            3'd2: begin
                                r_guardar <= 1'b1;
                                r_ocupado <= 1'b1;
                                r_estado  <= GUARDANDO;
                            end
                            3'd3: begin
`ifdef CONFIRMA_CERRAR_EN
                                r_estado   <= CONFIRMA;
                                r_confirma <= 1'b1;
                                r_contador <= TIMEOUT_CICLOS - 27'd1;
`else
                                r_cerrar <= 1'b1;
`endif
                            end
                            3'd4: if (w_mayus_ok) r_mayus <= (where_columna == 3'd1);
                            3'd5: if (w_rgb_ok) r_rgb <= w_rgb;
                            3'd6: if (w_scale_ok) r_scale <= w_scale;
                            default: ;
                        endcase
                    end
                end
                GUARDANDO: begin
                    if (guardar_ack) begin
                        r_guardar <= 1'b0;
                        r_ocupado <= 1'b0;
                        r_estado  <= REPOSO;
                    end
                end
`ifdef CONFIRMA_CERRAR_EN
                CONFIRMA: begin
                    // A confirming press outranks both the cancel conditions and the expiry.
                    if (elige && (where_fila == 3'd3)) begin
                        r_cerrar   <= 1'b1;
                        r_confirma <= 1'b0;
                        r_estado   <= REPOSO;
                    end else if (elige || (where_fila != 3'd3) || (r_contador == 27'd0)) begin
                        r_confirma <= 1'b0;
                        r_estado   <= REPOSO;
                    end else begin
                        r_contador <= r_contador - 27'd1;
                    end
                end
`endif
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign {text_red, text_green, text_blue} = r_rgb;
    assign char_scale   = r_scale;
    assign es_mayuscula = r_mayus;
    assign nuevo        = r_nuevo;
    assign guardar      = r_guardar;
    assign cerrar       = r_cerrar;
    assign ocupado      = r_ocupado;
`ifdef CONFIRMA_CERRAR_EN
    assign confirma_pendiente = r_confirma;
`else
    logic w_unused_timeout;
    assign w_unused_timeout   = ^TIMEOUT_CICLOS;
    assign confirma_pendiente = 1'b0;
`endif

endmodule
